// File: rtl/rgb_cmd_pkg.sv
// Shared definitions for the RGB UART command parser: parser state encoding,
// ASCII constants, the empty-RX sentinel and a hex digit decoder.
package rgb_cmd_pkg;

    typedef logic [2:0] parse_state_t;

    localparam parse_state_t ST_IDLE    = 3'd0;
    localparam parse_state_t ST_DIG     = 3'd1;
    localparam parse_state_t ST_TERM    = 3'd2;
    localparam parse_state_t ST_ERR     = 3'd3;
    localparam parse_state_t ST_ACK_OK  = 3'd4;
    localparam parse_state_t ST_ACK_ERR = 3'd5;

    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_K    = 8'h4B;
    localparam logic [7:0] CH_E    = 8'h45;

    localparam logic [31:0] RX_EMPTY = 32'hFFFF_FFFF;

    typedef struct packed {
        logic       valid;
        logic [3:0] nib;
    } hex_t;

    // Letters map via the low nibble: 'a'/'A' have low nibble 1, so +9 gives 10.
    function automatic hex_t hex_nibble(input logic [7:0] c);
        hex_t h;
        h.valid = 1'b1;
        h.nib   = 4'h0;
        if (c >= 8'h30 && c <= 8'h39) begin
            h.nib = c[3:0];
        end else if ((c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46)) begin
            h.nib = c[3:0] + 4'd9;
        end else begin
            h.valid = 1'b0;
        end
        return h;
    endfunction

endpackage

// File: rtl/rgb_uart_cmd_pwm.sv
// Three-channel PWM: prescaled 8-bit counter, duties reloaded only at the
// counter wrap so a period is never cut short or stretched.
module rgb_pwm #(
    parameter int          PWM_DIV   = 47,
    parameter logic [23:0] RESET_RGB = 24'h000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] duty,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam int PW = (PWM_DIV > 0) ? $clog2(PWM_DIV + 1) : 1;
    localparam logic [PW-1:0] PRESC_TC = PW'(PWM_DIV);

    logic [PW-1:0] presc;
    logic [7:0]    pc;
    logic [23:0]   duty_active;
    logic          step;

    assign step = (presc == PRESC_TC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            pc          <= '0;
            duty_active <= RESET_RGB;
            red         <= 1'b0;
            green       <= 1'b0;
            blue        <= 1'b0;
        end else begin
            presc <= step ? '0 : presc + PW'(1);
            if (step) begin
                pc <= pc + 8'd1;
                if (pc == 8'hFF) begin
                    duty_active <= duty;
                end
            end
            red   <= (pc < duty_active[23:16]);
            green <= (pc < duty_active[15:8]);
            blue  <= (pc < duty_active[7:0]);
        end
    end

endmodule

// File: rtl/rgb_uart_cmd.sv
// UART '#rrggbb' + CR/LF colour command parser driving rgb_pwm.
// Define RGB_CMD_ACK_EN to send 'K'/'E' acknowledgements over UART TX.
module rgb_uart_cmd #(
    parameter int          PWM_DIV   = 47,
    parameter logic [23:0] RESET_RGB = 24'h000000
) (
    input  logic        hw_clk,
    input  logic        resetn,
    input  logic [31:0] reg_dat_do,
    input  logic        reg_dat_wait,
    output logic        reg_dat_re,
    output logic        reg_dat_we,
    output logic [31:0] reg_dat_di,
    output logic        rgb_red,
    output logic        rgb_green,
    output logic        rgb_blue,
    output logic [23:0] duty_rgb
);
    import rgb_cmd_pkg::*;

`ifdef RGB_CMD_ACK_EN
    localparam parse_state_t ST_DONE_OK  = ST_ACK_OK;
    localparam parse_state_t ST_DONE_ERR = ST_ACK_ERR;
`else
    localparam parse_state_t ST_DONE_OK  = ST_IDLE;
    localparam parse_state_t ST_DONE_ERR = ST_IDLE;
`endif

    parse_state_t state;
    logic [2:0]   digits;
    logic [23:0]  shadow;
    logic [1:0]   holdoff;
    logic [7:0]   rx_byte;
    logic         in_ack;
    logic         take;
    logic         is_term;
    hex_t         hx;

    assign rx_byte = reg_dat_do[7:0];
    assign hx      = hex_nibble(rx_byte);
    assign is_term = (rx_byte == CH_CR) || (rx_byte == CH_LF);
    // holdoff masks the strobe cycle and the one after, while the UART updates its data port
    assign take    = (holdoff == 2'd0) && (reg_dat_do != RX_EMPTY) && !in_ack;

`ifdef RGB_CMD_ACK_EN
    assign in_ack     = (state == ST_ACK_OK) || (state == ST_ACK_ERR);
    assign reg_dat_we = in_ack;
    always_comb begin
        reg_dat_di = '0;
        if (state == ST_ACK_OK) begin
            reg_dat_di[7:0] = CH_K;
        end else if (state == ST_ACK_ERR) begin
            reg_dat_di[7:0] = CH_E;
        end
    end
`else
    assign in_ack     = 1'b0;
    assign reg_dat_we = 1'b0;
    assign reg_dat_di = '0;
`endif

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            digits     <= '0;
            shadow     <= '0;
            holdoff    <= '0;
            reg_dat_re <= 1'b0;
            duty_rgb   <= RESET_RGB;
        end else begin
            reg_dat_re <= take;
            if (take) begin
                holdoff <= 2'd2;
            end else if (holdoff != 2'd0) begin
                holdoff <= holdoff - 2'd1;
            end

            if (take) begin
                if (rx_byte == CH_HASH) begin
                    state  <= ST_DIG;
                    digits <= '0;
                    shadow <= '0;
                end else begin
                    case (state)
                        ST_DIG: begin
                            if (hx.valid) begin
                                shadow <= {shadow[19:0], hx.nib};
                                digits <= digits + 3'd1;
                                if (digits == 3'd5) begin
                                    state <= ST_TERM;
                                end
                            end else begin
                                state <= ST_ERR;
                            end
                        end
                        ST_TERM: begin
                            if (is_term) begin
                                duty_rgb <= shadow;
                                state    <= ST_DONE_OK;
                            end else begin
                                state <= ST_ERR;
                            end
                        end
                        ST_ERR: begin
                            if (is_term) begin
                                state <= ST_DONE_ERR;
                            end
                        end
                        default: ;
                    endcase
                end
            end else if (in_ack && !reg_dat_wait) begin
                state <= ST_IDLE;
            end
        end
    end

    rgb_pwm #(
        .PWM_DIV  (PWM_DIV),
        .RESET_RGB(RESET_RGB)
    ) u_pwm (
        .clk  (hw_clk),
        .rst_n(resetn),
        .duty (duty_rgb),
        .red  (rgb_red),
        .green(rgb_green),
        .blue (rgb_blue)
    );

endmodule

// File: tb/tb_rgb_uart_cmd.sv
// Scoreboard bench for rgb_uart_cmd: stimulus pushes expected commits and acks,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_rgb_uart_cmd;

`ifdef RGB_CMD_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif
    localparam logic [23:0] RST_RGB = 24'h102030;

    logic        hw_clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] reg_dat_do = 32'hFFFF_FFFF;
    logic        reg_dat_wait = 1'b0;
    logic        reg_dat_re;
    logic        reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        rgb_red;
    logic        rgb_green;
    logic        rgb_blue;
    logic [23:0] duty_rgb;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [23:0] exp_duty[$];
    logic [7:0]  exp_ack[$];
    logic [23:0] prev_duty;

    rgb_uart_cmd #(
        .PWM_DIV  (0),
        .RESET_RGB(RST_RGB)
    ) dut (
        .hw_clk      (hw_clk),
        .resetn      (resetn),
        .reg_dat_do  (reg_dat_do),
        .reg_dat_wait(reg_dat_wait),
        .reg_dat_re  (reg_dat_re),
        .reg_dat_we  (reg_dat_we),
        .reg_dat_di  (reg_dat_di),
        .rgb_red     (rgb_red),
        .rgb_green   (rgb_green),
        .rgb_blue    (rgb_blue),
        .duty_rgb    (duty_rgb)
    );

    always #5 hw_clk = ~hw_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    // Monitor: every duty change and every accepted TX write must be expected
    always @(negedge hw_clk) begin
        if (!resetn) begin
            prev_duty = duty_rgb;
        end else begin
            if (duty_rgb !== prev_duty) begin
                if (exp_duty.size() == 0) flag("duty_unexpected", {8'h0, duty_rgb});
                else check("duty_commit", {8'h0, duty_rgb}, {8'h0, exp_duty.pop_front()});
                prev_duty = duty_rgb;
            end
            if (reg_dat_we && !reg_dat_wait) begin
                if (exp_ack.size() == 0) flag("ack_unexpected", reg_dat_di);
                else check("ack_byte", reg_dat_di, {24'h0, exp_ack.pop_front()});
            end
        end
    end

    task automatic expect_cmd(input logic commit, input logic [23:0] d, input logic [7:0] ack);
        if (commit) exp_duty.push_back(d);
        if (ACK_EN) exp_ack.push_back(ack);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        @(negedge hw_clk);
        reg_dat_do = {24'h0, b};
        do begin
            @(posedge hw_clk);
            #1;
            n++;
        end while (!reg_dat_re && n < 2000);
        if (!reg_dat_re) flag("rx_read_timeout", {24'h0, b});
        reg_dat_do = 32'hFFFF_FFFF;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge hw_clk);
    endtask

    task automatic wait_duty(input string name, input logic [23:0] d);
        int unsigned n;
        n = 0;
        while (duty_rgb !== d && n < 200) begin
            @(negedge hw_clk);
            n++;
        end
        check(name, {8'h0, duty_rgb}, {8'h0, d});
    endtask

    task automatic count_high(output int unsigned r, output int unsigned g, output int unsigned b);
        r = 0; g = 0; b = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge hw_clk);
            if (rgb_red)   r++;
            if (rgb_green) g++;
            if (rgb_blue)  b++;
        end
    endtask

    initial begin
        int unsigned r, g, b, run, n;
        logic prev_red;

        // Reset state
        wait_cycles(3);
        check("rst_duty", {8'h0, duty_rgb}, {8'h0, RST_RGB});
        check("rst_re", {31'h0, reg_dat_re}, 32'h0);
        check("rst_we", {31'h0, reg_dat_we}, 32'h0);
        check("rst_di", reg_dat_di, 32'h0);
        check("rst_rgb", {29'h0, rgb_red, rgb_green, rgb_blue}, 32'h0);
        @(posedge hw_clk); #2;
        resetn = 1'b1;

        // Basic commit and duty ratios
        expect_cmd(1'b1, 24'hFF8000, 8'h4B);
        send_str("#FF8000\015");
        wait_duty("duty_ff8000", 24'hFF8000);
        wait_cycles(300);
        count_high(r, g, b);
        check("pwm_red_255", r, 255);
        check("pwm_green_128", g, 128);
        check("pwm_blue_0", b, 0);

        // Bad digit: no commit, error ack; then zero duty
        expect_cmd(1'b0, 24'h0, 8'h45);
        send_str("#12G456\n");
        wait_cycles(10);
        check("duty_kept", {8'h0, duty_rgb}, 32'h00FF8000);
        expect_cmd(1'b1, 24'h000000, 8'h4B);
        send_str("#000000\n");
        wait_duty("duty_zero", 24'h000000);

        // Restart on '#'
        expect_cmd(1'b1, 24'hABCDEF, 8'h4B);
        send_str("#12#abcdef\n");
        wait_duty("duty_abcdef", 24'hABCDEF);

        // Ack held off by TX busy
`ifdef RGB_CMD_ACK_EN
        @(posedge hw_clk); #2;
        reg_dat_wait = 1'b1;
`endif
        expect_cmd(1'b1, 24'h010101, 8'h4B);
        send_str("#010101\015");
        wait_duty("duty_010101", 24'h010101);
`ifdef RGB_CMD_ACK_EN
        n = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge hw_clk);
            if (!(reg_dat_we === 1'b1 && reg_dat_di === 32'h0000_004B)) n++;
        end
        check("ack_hold_bad_cycles", n, 0);
        @(posedge hw_clk); #2;
        reg_dat_wait = 1'b0;
`endif
        wait_cycles(10);

        // Mid-period commit must wait for the counter wrap
        expect_cmd(1'b1, 24'h400000, 8'h4B);
        send_str("#400000\n");
        wait_cycles(600);
        prev_red = rgb_red;
        n = 0;
        while (!(prev_red && !rgb_red) && n < 600) begin
            prev_red = rgb_red;
            @(negedge hw_clk);
            n++;
        end
        expect_cmd(1'b1, 24'hC00000, 8'h4B);
        send_str("#C00000\n");
        wait_duty("duty_c00000", 24'hC00000);
        wait_cycles(3);
        check("red_old_duty_low", {31'h0, rgb_red}, 32'h0);
        n = 0;
        while (!rgb_red && n < 400) begin
            @(negedge hw_clk);
            n++;
        end
        run = 0;
        while (rgb_red && run < 400) begin
            run++;
            @(negedge hw_clk);
        end
        check("red_new_high_run", run, 192);

        // Reset mid-command
        send_str("#12");
        @(negedge hw_clk);
        resetn = 1'b0;
        #1;
        check("rst2_re", {31'h0, reg_dat_re}, 32'h0);
        check("rst2_we", {31'h0, reg_dat_we}, 32'h0);
        check("rst2_rgb", {29'h0, rgb_red, rgb_green, rgb_blue}, 32'h0);
        check("rst2_duty", {8'h0, duty_rgb}, {8'h0, RST_RGB});
        wait_cycles(2);
        @(posedge hw_clk); #2;
        resetn = 1'b1;
        send_str("34\n");
        wait_cycles(20);
        check("no_resp_duty", {8'h0, duty_rgb}, {8'h0, RST_RGB});
        expect_cmd(1'b1, 24'h010203, 8'h4B);
        send_str("#010203\n");
        wait_duty("duty_010203", 24'h010203);
        wait_cycles(20);

        check("duty_queue_left", exp_duty.size(), 0);
        check("ack_queue_left", exp_ack.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
